// File: rtl/rtc_frame_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_frame_uart_tx
//  Description : Captures a packed BCD date/time snapshot on a one-cycle
//                trigger and sends it as an ASCII text line or as a
//                checksummed binary packet on an 8N1 UART line.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_frame_uart_tx #(
  parameter int          CLK_FREQ   = 50_000_000,
  parameter int          BAUD       = 115200,
  parameter int          NUM_FIELDS = 6,
  parameter int          ASCII_MODE = 1,
  parameter logic [7:0]  SEP        = 8'h20,
  parameter logic [7:0]  HEADER     = 8'hAA
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    send_en,
  input  logic [8*NUM_FIELDS-1:0] data,
  output logic                    uart_tx,
  output logic                    busy,
  output logic                    frame_done,
  output logic [7:0]              drop_cnt
);

  localparam int BIT_CYC   = CLK_FREQ / BAUD;
  localparam int CNT_W     = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  // Byte index is sized for the largest text frame (16 fields).
  localparam int IDX_W     = $clog2(3*16+1);
  localparam int FRAME_LEN = (ASCII_MODE != 0) ? 3*NUM_FIELDS+1 : NUM_FIELDS+2;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        baud_cnt, baud_n;
  logic [2:0]              bit_idx, bit_n;
  logic [IDX_W-1:0]        byte_idx, byte_n;
  logic                    tx_n, busy_n, done_n;
  logic [8*NUM_FIELDS-1:0] snap;
  logic [7:0]              frame_bytes [0:(1<<IDX_W)-1];
  logic [7:0]              cur_byte;
  logic                    baud_last;

  // BCD nibble to ASCII digit; non-decimal nibbles are shown as '?'.
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
  endfunction

  // Latch the snapshot on an accepted trigger; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (send_en && !busy) snap <= data;
  end

  // Frame byte table derived combinationally from the snapshot (no frame RAM).
  always_comb begin
    logic [7:0] chk;
    chk         = 8'h00;
    frame_bytes = '{default: 8'h00};
    if (ASCII_MODE != 0) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        frame_bytes[IDX_W'(3*f)]   = nib_to_ascii(snap[8*(NUM_FIELDS-1-f)+4 +: 4]);
        frame_bytes[IDX_W'(3*f+1)] = nib_to_ascii(snap[8*(NUM_FIELDS-1-f) +: 4]);
        frame_bytes[IDX_W'(3*f+2)] = SEP;
      end
      // The separator slot after the last field becomes CR, then LF closes the line.
      frame_bytes[IDX_W'(3*NUM_FIELDS-1)] = 8'h0D;
      frame_bytes[IDX_W'(3*NUM_FIELDS)]   = 8'h0A;
    end else begin
      frame_bytes[IDX_W'(0)] = HEADER;
      for (int f = 0; f < NUM_FIELDS; f++) begin
        frame_bytes[IDX_W'(f+1)] = snap[8*(NUM_FIELDS-1-f) +: 8];
        chk = chk ^ snap[8*(NUM_FIELDS-1-f) +: 8];
      end
      frame_bytes[IDX_W'(NUM_FIELDS+1)] = chk;
    end
  end

  assign cur_byte  = frame_bytes[byte_idx];
  assign baud_last = (baud_cnt == BAUD_LAST);

  // Next-state and next-output logic; line level is computed one cycle ahead so uart_tx is a flop.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    tx_n    = uart_tx;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (send_en) begin
          state_n = START;
          baud_n  = '0;
          byte_n  = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (baud_last) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = 3'd0;
          tx_n    = cur_byte[0];
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_idx + 3'd1;
            tx_n  = cur_byte[bit_idx + 3'd1];
          end
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (byte_idx == LAST_BYTE) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = START;
            byte_n  = byte_idx + IDX_W'(1);
            tx_n    = 1'b0;
          end
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset forces the line idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      byte_idx   <= '0;
      uart_tx    <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_idx    <= bit_n;
      byte_idx   <= byte_n;
      uart_tx    <= tx_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

  // Count triggers that arrive while a frame is in progress, saturating at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else if (send_en && busy && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire
